// File: rtl/qr_stream_decode_if.sv
// Handshake bundle for qr_stream_decode: frame load on the master side,
// byte stream plus end-of-frame status back from the decoder.
interface qr_stream_decode_if #(
    parameter int unsigned MAX_BYTES = 26
);
    localparam int unsigned IN_W = 12 + 8 * MAX_BYTES;

    logic            start;
    logic [IN_W-1:0] in;
    logic            out_ready;
    logic [7:0]      code_out;
    logic            valid;
    logic            finish;
    logic            error;
    logic            busy;

    modport master (
        output start, in, out_ready,
        input  code_out, valid, finish, error, busy
    );

    modport slave (
        input  start, in, out_ready,
        output code_out, valid, finish, error, busy
    );
endinterface

// File: rtl/qr_stream_decode.sv
// Byte-mode QR frame unpacker: latches a whole frame on start, checks the header
// and streams data bytes out under valid/out_ready, ending with a finish pulse.
module qr_stream_decode #(
    parameter int unsigned MAX_BYTES = 26,
    parameter logic [3:0]  MODE_BYTE = 4'b0100
) (
    input logic                clk,
    input logic                rst_n,
    qr_stream_decode_if.slave  bus
);
    localparam int unsigned IN_W  = 12 + 8 * MAX_BYTES;
    localparam int unsigned DW    = IN_W - 12;
    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);

    typedef enum logic [1:0] {StIdle, StSend, StFin, StErr} state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      buf_q, buf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [7:0]         code_out_q, code_out_d;
    logic               valid_q, valid_d;
    logic               finish_q, finish_d;
    logic               error_q, error_d;
    logic               busy_q, busy_d;

    logic [3:0]         mode_in;
    logic [7:0]         cnt_in;
    logic [CNT_W-1:0]   sent_inc;

    assign mode_in  = bus.in[IN_W-1 -: 4];
    assign cnt_in   = bus.in[IN_W-5 -: 8];
    assign sent_inc = sent_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        sent_d  = sent_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    buf_d   = bus.in[DW-1:0];
                    count_d = cnt_in[CNT_W-1:0];
                    sent_d  = '0;
                    if (mode_in != MODE_BYTE || {24'd0, cnt_in} > MAX_BYTES) begin
                        state_d = StErr;
                    end else if (cnt_in == 8'd0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StSend;
                    end
                end
            end
            StSend: begin
                // valid is high throughout SEND, so out_ready alone marks a transfer
                if (bus.out_ready) begin
                    buf_d  = {buf_q[DW-9:0], 8'h00};
                    sent_d = sent_inc;
                    if (sent_inc == count_q) begin
                        state_d = StFin;
                    end
                end
            end
            StFin:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are computed from the next state so they register alongside it
        valid_d    = (state_d == StSend);
        code_out_d = valid_d ? buf_d[DW-1 -: 8] : 8'h00;
        finish_d   = (state_d == StFin) || (state_d == StErr);
        error_d    = (state_d == StErr);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            count_q    <= '0;
            sent_q     <= '0;
            code_out_q <= 8'h00;
            valid_q    <= 1'b0;
            finish_q   <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            count_q    <= count_d;
            sent_q     <= sent_d;
            code_out_q <= code_out_d;
            valid_q    <= valid_d;
            finish_q   <= finish_d;
            error_q    <= error_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.code_out = code_out_q;
    assign bus.valid    = valid_q;
    assign bus.finish   = finish_q;
    assign bus.error    = error_q;
    assign bus.busy     = busy_q;

    a_err_with_finish: assert property (@(posedge clk) disable iff (!rst_n)
        error_q |-> finish_q);
    a_no_valid_at_finish: assert property (@(posedge clk) disable iff (!rst_n)
        finish_q |-> !valid_q);
endmodule
